encoder_pipe: RTL and testbench
===============================

Name: encoder_pipe

Overview:
- Parametrised, pipelined, multi-lane successor to the single-lane 4-bit combinational signed encoder in the multsigned datapath.
- Each lane takes a two's-complement operand and computes floor((x + 2^(SHIFT-1)) / 2^SHIFT), i.e. arithmetic shift right by SHIFT with round-half-up.
- Each lane result is emitted in sign-magnitude form.
- Sits between the operand buffers and the signed multiplier array; has valid/ready handshakes, a 2-stage pipeline with backpressure, and a flush.

Parameters:
- LANES, 4, number of independent lanes per beat.
- IN_W, 4, input lane width, two's complement; legal range 2..16.
- SHIFT, 1, right-shift amount; legal range 1..IN_W-1; violating values are rejected by an elaboration-time assertion.
- OUT_W, IN_W-SHIFT+1, output lane width (derived, not overridable): 1 sign bit plus IN_W-SHIFT magnitude bits.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset, synchronous, active-low.
- flush_i  in  1  synchronous pipeline clear.
- in_valid_i  in  1  input beat valid.
- in_ready_o  out  1  input beat accepted when in_valid_i & in_ready_o.
- in_data_i  in  LANES*IN_W  lane k at [k*IN_W +: IN_W].
- out_valid_o  out  1  output beat valid.
- out_ready_i  in  1  downstream accepts.
- out_data_o  out  LANES*OUT_W  lane k at [k*OUT_W +: OUT_W]; MSB = sign.
- out_zero_o  out  LANES  bit k set when lane k magnitude is 0.
- stat_beats_o  out  16  output-beat counter (see Optional Feature).

Behaviour:
- Reset (rst_ni low at a rising edge): both stage valids 0; out_valid_o=0; out_data_o=0; out_zero_o=0; stat_beats_o=0. in_ready_o=0 while rst_ni is low.
- Stage 1 (S1): on input handshake, register per-lane r = (sext(x) + 2^(SHIFT-1)) >>> SHIFT. Compute in IN_W+1 bits so the add cannot overflow.
- Stage 2 (S2): from S1, register the sign-magnitude form:
  - sign = r<0;
  - mag = |r| truncated to OUT_W-1 bits (lossless by construction);
  - zero flag = (mag==0).
  - Never produce negative zero: r=0 gives sign 0.
- Range check, IN_W=4 / SHIFT=1: +7 -> +4, -8 -> -4 (4'b1100), -1 -> 0, -3 -> -1, +1 -> +1.
- Outputs out_data_o, out_zero_o and out_valid_o are driven directly from S2 registers; no combinational path from in_data_i.
- Latency: 2 cycles from input handshake to out_valid_o, with no stall.
- Throughput: 1 beat/cycle.
- Stage advance rules:
  - S2 loads when S1 is valid and (S2 empty or out_ready_i).
  - S1 loads when in_valid_i & in_ready_o.
  - in_ready_o = !flush_i & (S1 empty or S2 loads this cycle).
  - in_ready_o is combinational from out_ready_i; this is the only comb path.
- Backpressure: while out_ready_i=0 with S2 full, S2 holds its data stable and out_valid_o stays 1. S1 fills, then in_ready_o drops. Nothing is dropped or duplicated.
- Bubble collapse: an empty S2 accepts from S1 regardless of out_ready_i.
- Simultaneous output handshake and S1->S2 transfer in the same cycle: S2 is replaced, with no bubble.
- flush_i=1:
  - Both stage valids clear at the next edge.
  - in_ready_o=0 that cycle; any concurrent in_valid_i beat is not accepted.
  - out_valid_o may be 1 in the flush cycle; an out handshake in that cycle still counts as delivered.
- Reset mid-stream: reset overrides flush and handshakes; in-flight beats are discarded.
- Data registers need no reset except out_data_o and out_zero_o, which reset to 0.

Optional Feature:
- Macro ENCODER_PIPE_STATS_EN.
- Defined: stat_beats_o increments by 1 on every output handshake (out_valid_o & out_ready_i). It saturates at 16'hFFFF and clears only on reset; flush does not clear it.
- Undefined: stat_beats_o is tied to 16'h0000, no counter logic is synthesised, and the port list is unchanged.

Test Plan:
- Basic path, LANES=4, IN_W=4, SHIFT=1, out_ready_i=1: send 16'h8F37 (lanes3..0 = -8,-1,+3,+7) -> 2 cycles later out_data_o=16'hC024, out_zero_o=4'b0100.
- Rounding and sign: send 16'hD951 (-3,-7,+5,+1) -> out_data_o=16'h9B31, out_zero_o=4'b0000. Send 16'hFFFF -> 16'h0000, out_zero_o=4'b1111, no negative zero.
- Backpressure: stream 5 beats with out_ready_i=0 from cycle 2 -> in_ready_o low after 2 accepted beats, out_data_o stable. Release out_ready_i -> all 5 beats out in order, 1/cycle, none lost or duplicated.
- Flush: with both stages full, pulse flush_i 1 cycle with in_valid_i=1 -> next cycle out_valid_o=0 and the flush-cycle beat is not accepted. A following beat emerges with 2-cycle latency.
- Reset: assert rst_ni=0 for 1 cycle mid-stream -> next cycle out_valid_o=0, out_data_o=0, stat_beats_o=0. Normal operation resumes after release.
- Stats, with ENCODER_PIPE_STATS_EN: 70000 back-to-back beats -> stat_beats_o=16'hFFFF, holding. Without the macro -> stat_beats_o stays 0.

Source files
------------

// File: rtl/encoder_pipe.sv
// Multi-lane pipelined signed encoder: round-half-up arithmetic shift right, sign-magnitude output.
// Optional output-beat counter enabled by defining ENCODER_PIPE_STATS_EN.

module encoder_lane #(
    parameter int IN_W  = 4,
    parameter int SHIFT = 1,
    parameter int OUT_W = IN_W - SHIFT + 1
) (
    input  logic [IN_W-1:0]  x_i,
    output logic [IN_W:0]    r_o,
    input  logic [IN_W:0]    r_i,
    output logic [OUT_W-1:0] sm_o,
    output logic             zero_o
);
    localparam int R_W = IN_W + 1;
    localparam logic [R_W-1:0] HALF = R_W'(1) << (SHIFT - 1);

    logic signed [R_W-1:0] xs;
    logic signed [R_W-1:0] sum;
    logic signed [R_W-1:0] abs_r;
    logic [OUT_W-2:0]      mag;

    always_comb begin
        xs     = $signed({x_i[IN_W-1], x_i});
        sum    = xs + $signed(HALF);
        r_o    = sum >>> SHIFT;
        abs_r  = r_i[R_W-1] ? -$signed(r_i) : $signed(r_i);
        // |r| always fits OUT_W-1 bits, so the truncation is lossless
        mag    = (OUT_W-1)'(abs_r);
        zero_o = (mag == '0);
        sm_o   = {r_i[R_W-1] & !zero_o, mag};
    end
endmodule

module encoder_pipe #(
    parameter int LANES = 4,
    parameter int IN_W  = 4,
    parameter int SHIFT = 1
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            flush_i,
    input  logic                            in_valid_i,
    output logic                            in_ready_o,
    input  logic [LANES*IN_W-1:0]           in_data_i,
    output logic                            out_valid_o,
    input  logic                            out_ready_i,
    output logic [LANES*(IN_W-SHIFT+1)-1:0] out_data_o,
    output logic [LANES-1:0]                out_zero_o,
    output logic [15:0]                     stat_beats_o
);
    localparam int OUT_W = IN_W - SHIFT + 1;

    if (IN_W < 2 || IN_W > 16 || SHIFT < 1 || SHIFT > IN_W - 1) begin : g_param_err
        $error("encoder_pipe: illegal IN_W/SHIFT combination");
    end

    logic s1_vld_q, s1_vld_d;
    logic s2_vld_q, s2_vld_d;
    logic s1_load, s2_load;

    logic [LANES-1:0][IN_W:0]    r_new;
    logic [LANES-1:0][IN_W:0]    s1_r_q, s1_r_d;
    logic [LANES-1:0][OUT_W-1:0] sm_new;
    logic [LANES-1:0][OUT_W-1:0] out_data_q, out_data_d;
    logic [LANES-1:0]            zero_new;
    logic [LANES-1:0]            out_zero_q, out_zero_d;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        encoder_lane #(.IN_W(IN_W), .SHIFT(SHIFT), .OUT_W(OUT_W)) u_lane (
            .x_i    (in_data_i[k*IN_W +: IN_W]),
            .r_o    (r_new[k]),
            .r_i    (s1_r_q[k]),
            .sm_o   (sm_new[k]),
            .zero_o (zero_new[k])
        );
    end

    always_comb begin
        s2_load    = s1_vld_q & (!s2_vld_q | out_ready_i);
        in_ready_o = rst_ni & !flush_i & (!s1_vld_q | s2_load);
        s1_load    = in_valid_i & in_ready_o;

        s1_vld_d = s1_vld_q;
        if (flush_i)      s1_vld_d = 1'b0;
        else if (s1_load) s1_vld_d = 1'b1;
        else if (s2_load) s1_vld_d = 1'b0;

        s2_vld_d = s2_vld_q;
        if (flush_i)          s2_vld_d = 1'b0;
        else if (s2_load)     s2_vld_d = 1'b1;
        else if (out_ready_i) s2_vld_d = 1'b0;

        s1_r_d     = s1_load ? r_new    : s1_r_q;
        out_data_d = s2_load ? sm_new   : out_data_q;
        out_zero_d = s2_load ? zero_new : out_zero_q;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            s1_vld_q   <= 1'b0;
            s2_vld_q   <= 1'b0;
            out_data_q <= '0;
            out_zero_q <= '0;
        end else begin
            s1_vld_q   <= s1_vld_d;
            s2_vld_q   <= s2_vld_d;
            out_data_q <= out_data_d;
            out_zero_q <= out_zero_d;
        end
    end

    // S1 payload is qualified by s1_vld_q, so it carries no reset
    always_ff @(posedge clk_i) begin
        s1_r_q <= s1_r_d;
    end

    assign out_valid_o = s2_vld_q;
    assign out_data_o  = out_data_q;
    assign out_zero_o  = out_zero_q;

`ifdef ENCODER_PIPE_STATS_EN
    logic [15:0] stat_q, stat_d;

    always_comb begin
        stat_d = stat_q;
        if (out_valid_o && out_ready_i && stat_q != 16'hFFFF) stat_d = stat_q + 16'd1;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) stat_q <= '0;
        else         stat_q <= stat_d;
    end

    assign stat_beats_o = stat_q;
`else
    assign stat_beats_o = 16'h0000;
`endif
endmodule

// File: tb/tb_encoder_pipe.sv
// Scoreboard bench for encoder_pipe (LANES=4, IN_W=4, SHIFT=1).
module tb_encoder_pipe;
    localparam int LANES = 4;
    localparam int IN_W  = 4;
    localparam int SHIFT = 1;
    localparam int OUT_W = IN_W - SHIFT + 1;
    localparam int IDW   = LANES * IN_W;
    localparam int ODW   = LANES * OUT_W;

    logic             clk_i = 1'b0;
    logic             rst_ni = 1'b0;
    logic             flush_i = 1'b0;
    logic             in_valid_i = 1'b0;
    logic             in_ready_o;
    logic [IDW-1:0]   in_data_i = '0;
    logic             out_valid_o;
    logic             out_ready_i = 1'b0;
    logic [ODW-1:0]   out_data_o;
    logic [LANES-1:0] out_zero_o;
    logic [15:0]      stat_beats_o;

    int errors = 0;
    int checks = 0;
    int out_cnt = 0;
    int exp_stat = 0;
    logic [ODW+LANES-1:0] sb[$];

    encoder_pipe #(.LANES(LANES), .IN_W(IN_W), .SHIFT(SHIFT)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .flush_i      (flush_i),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .in_data_i    (in_data_i),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .out_data_o   (out_data_o),
        .out_zero_o   (out_zero_o),
        .stat_beats_o (stat_beats_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference: floor division written out explicitly, then sign-magnitude packing.
    function automatic logic [ODW+LANES-1:0] model(input logic [IDW-1:0] d);
        logic [ODW-1:0]   data;
        logic [LANES-1:0] zero;
        logic [IN_W-1:0]  xl;
        logic [OUT_W-1:0] lane;
        int x, v, dv, q, mag;
        data = '0;
        zero = '0;
        for (int k = 0; k < LANES; k++) begin
            xl = d[k*IN_W +: IN_W];
            x  = int'($signed(xl));
            v  = x + (1 << (SHIFT - 1));
            dv = 1 << SHIFT;
            q  = v / dv;
            if ((v % dv) != 0 && v < 0) q = q - 1;
            mag  = (q < 0) ? -q : q;
            lane = OUT_W'(mag);
            lane[OUT_W-1] = (q < 0);
            data[k*OUT_W +: OUT_W] = lane;
            zero[k] = (mag == 0);
        end
        return {data, zero};
    endfunction

    // Scoreboard monitor: pop on output handshake, drop in-flight on flush/reset, push on accept.
    always @(negedge clk_i) begin
        logic [ODW+LANES-1:0] exp;
        if (!rst_ni) begin
            sb.delete();
            exp_stat = 0;
        end else begin
            if (out_valid_o && out_ready_i) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: got data=%h zero=%b, want no beat", out_data_o, out_zero_o);
                end else begin
                    exp = sb.pop_front();
                    if ({out_data_o, out_zero_o} !== exp) begin
                        errors++;
                        $display("FAIL sb_beat: got data=%h zero=%b, want data=%h zero=%b",
                                 out_data_o, out_zero_o, exp[ODW+LANES-1:LANES], exp[LANES-1:0]);
                    end
                end
                out_cnt++;
`ifdef ENCODER_PIPE_STATS_EN
                if (exp_stat < 16'hFFFF) exp_stat++;
`endif
            end
            if (flush_i) sb.delete();
            if (in_valid_i && in_ready_o) sb.push_back(model(in_data_i));
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset;
        rst_ni = 1'b0; in_valid_i = 1'b1; out_ready_i = 1'b1; flush_i = 1'b0;
        tick(); tick();
        @(negedge clk_i);
        checks++;
        if ({out_valid_o, out_data_o, out_zero_o, stat_beats_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b d=%h z=%b s=%h, want all 0",
                     out_valid_o, out_data_o, out_zero_o, stat_beats_o);
        end
        checks++;
        if (in_ready_o !== 1'b0) begin
            errors++; $display("FAIL reset_ready: got %b want 0", in_ready_o);
        end
        tick();
        rst_ni = 1'b1; in_valid_i = 1'b0;
        tick();
    endtask

    task automatic test_basic;
        out_ready_i = 1'b1;
        in_valid_i = 1'b1; in_data_i = 16'h8F37;
        @(negedge clk_i);
        checks++;
        if (in_ready_o !== 1'b1) begin errors++; $display("FAIL basic_ready: got %b want 1", in_ready_o); end
        tick();
        in_valid_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if (out_valid_o !== 1'b0) begin errors++; $display("FAIL basic_latency1: got %b want 0", out_valid_o); end
        tick();
        @(negedge clk_i);
        checks++;
        if ({out_valid_o, out_data_o, out_zero_o} !== {1'b1, 16'hC024, 4'b0100}) begin
            errors++;
            $display("FAIL basic_8F37: got v=%b d=%h z=%b, want v=1 d=c024 z=0100", out_valid_o, out_data_o, out_zero_o);
        end
        tick(); tick();
    endtask

    task automatic test_round;
        out_ready_i = 1'b1;
        in_valid_i = 1'b1; in_data_i = 16'hD951; tick();
        in_data_i = 16'hFFFF; tick();
        in_valid_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if ({out_data_o, out_zero_o} !== {16'h9B31, 4'b0000}) begin
            errors++; $display("FAIL round_D951: got d=%h z=%b, want d=9b31 z=0000", out_data_o, out_zero_o);
        end
        tick();
        @(negedge clk_i);
        checks++;
        if ({out_data_o, out_zero_o} !== {16'h0000, 4'b1111}) begin
            errors++; $display("FAIL round_FFFF: got d=%h z=%b, want d=0000 z=1111", out_data_o, out_zero_o);
        end
        tick();
        // Back-to-back random beats at full rate: every cycle must be accepted
        begin
            int acc = 0;
            for (int i = 0; i < 20; i++) begin
                in_valid_i = 1'b1; in_data_i = IDW'($urandom());
                @(negedge clk_i);
                if (in_ready_o) acc++;
                tick();
            end
            in_valid_i = 1'b0;
            checks++;
            if (acc !== 20) begin errors++; $display("FAIL round_throughput: got %0d accepts want 20", acc); end
        end
        tick(); tick(); tick();
    endtask

    task automatic test_backpressure;
        logic [IDW-1:0] beats[5];
        logic [ODW-1:0] held;
        int acc = 0;
        int out0 = out_cnt;
        held = '0;
        beats = '{16'h8F37, 16'hD951, 16'h1234, 16'h7A5C, 16'hE0F9};
        for (int cyc = 0; cyc < 25; cyc++) begin
            in_valid_i  = (acc < 5);
            in_data_i   = (acc < 5) ? beats[acc] : '0;
            out_ready_i = (cyc < 2) || (cyc >= 8);
            @(negedge clk_i);
            if (cyc == 4) begin
                checks++;
                if ({in_ready_o, out_valid_o} !== 2'b01 || acc !== 2) begin
                    errors++;
                    $display("FAIL bp_stall: got ready=%b valid=%b acc=%0d, want ready=0 valid=1 acc=2", in_ready_o, out_valid_o, acc);
                end
                held = out_data_o;
            end
            if (cyc == 7) begin
                checks++;
                if (out_data_o !== held || out_valid_o !== 1'b1) begin
                    errors++; $display("FAIL bp_hold: got d=%h v=%b, want d=%h v=1", out_data_o, out_valid_o, held);
                end
            end
            if (in_valid_i && in_ready_o) acc++;
            tick();
            if (cyc == 11) begin
                checks++;
                if (out_cnt - out0 !== 4) begin errors++; $display("FAIL bp_rate4: got %0d want 4", out_cnt - out0); end
            end
            if (cyc == 12) begin
                checks++;
                if (out_cnt - out0 !== 5) begin errors++; $display("FAIL bp_rate5: got %0d want 5", out_cnt - out0); end
            end
        end
        checks++;
        if (out_cnt - out0 !== 5) begin errors++; $display("FAIL bp_total: got %0d want 5", out_cnt - out0); end
    endtask

    task automatic test_flush;
        logic [ODW+LANES-1:0] exp;
        out_ready_i = 1'b0;
        in_valid_i = 1'b1; in_data_i = 16'h1111; tick();
        in_data_i = 16'h2222; tick();
        flush_i = 1'b1; in_data_i = 16'h3333;
        @(negedge clk_i);
        checks++;
        if (in_ready_o !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b want 0", in_ready_o); end
        tick();
        flush_i = 1'b0; in_valid_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if (out_valid_o !== 1'b0) begin errors++; $display("FAIL flush_clear: got %b want 0", out_valid_o); end
        out_ready_i = 1'b1;
        tick();
        in_valid_i = 1'b1; in_data_i = 16'h4C7B;
        exp = model(16'h4C7B);
        tick();
        in_valid_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if (out_valid_o !== 1'b0) begin errors++; $display("FAIL flush_lat1: got %b want 0", out_valid_o); end
        tick();
        @(negedge clk_i);
        checks++;
        if ({out_valid_o, out_data_o, out_zero_o} !== {1'b1, exp}) begin
            errors++; $display("FAIL flush_after: got v=%b d=%h, want v=1 d=%h", out_valid_o, out_data_o, exp[ODW+LANES-1:LANES]);
        end
        tick(); tick();
    endtask

    task automatic test_reset_mid;
        out_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid_i = 1'b1; in_data_i = IDW'($urandom()); tick();
        end
        rst_ni = 1'b0;
        @(negedge clk_i);
        checks++;
        if (in_ready_o !== 1'b0) begin errors++; $display("FAIL rstmid_ready: got %b want 0", in_ready_o); end
        tick();
        rst_ni = 1'b1; in_valid_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if ({out_valid_o, out_data_o, out_zero_o, stat_beats_o} !== '0) begin
            errors++;
            $display("FAIL rstmid_outputs: got v=%b d=%h z=%b s=%h, want all 0", out_valid_o, out_data_o, out_zero_o, stat_beats_o);
        end
        tick();
        in_valid_i = 1'b1; in_data_i = 16'h9E07; tick();
        in_valid_i = 1'b0; tick();
        @(negedge clk_i);
        checks++;
        if (out_valid_o !== 1'b1) begin errors++; $display("FAIL rstmid_resume: got %b want 1", out_valid_o); end
        tick(); tick();
    endtask

    task automatic test_back_to_back;
        int n = 0;
        for (int i = 0; i < 80; i++) begin
            in_valid_i  = ($urandom_range(0, 3) != 0);
            in_data_i   = IDW'($urandom());
            out_ready_i = ($urandom_range(0, 2) != 0);
            tick();
        end
        in_valid_i = 1'b0; out_ready_i = 1'b1;
        while (sb.size() != 0 && n < 20) begin tick(); n++; end
        tick();
        checks++;
        if (sb.size() !== 0 || out_valid_o !== 1'b0) begin
            errors++; $display("FAIL b2b_drain: got pending=%0d valid=%b, want 0 and 0", sb.size(), out_valid_o);
        end
    endtask

    task automatic test_stats;
        checks++;
        if (stat_beats_o !== 16'(exp_stat)) begin
            errors++; $display("FAIL stats_count: got %h want %h", stat_beats_o, 16'(exp_stat));
        end
`ifdef ENCODER_PIPE_STATS_EN
        out_ready_i = 1'b1; in_valid_i = 1'b1;
        for (int i = 0; i < 70000; i++) begin
            in_data_i = IDW'($urandom()); tick();
        end
        in_valid_i = 1'b0;
        repeat (4) tick();
        checks++;
        if (stat_beats_o !== 16'hFFFF) begin errors++; $display("FAIL stats_sat: got %h want ffff", stat_beats_o); end
`endif
        out_ready_i = 1'b1;
        flush_i = 1'b1; tick(); flush_i = 1'b0;
        in_valid_i = 1'b1;
        repeat (3) begin in_data_i = IDW'($urandom()); tick(); end
        in_valid_i = 1'b0;
        repeat (4) tick();
        checks++;
        if (stat_beats_o !== 16'(exp_stat)) begin
            errors++; $display("FAIL stats_hold: got %h want %h", stat_beats_o, 16'(exp_stat));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_round();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        test_stats();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
